// File: rtl/eth_spi_pkg.sv
// Shared types and default parameters for the Ethernet-link SPI master.
package eth_spi_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DIV_W    = 8;
  localparam int DEF_CS_COUNT = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_XFER = 3'd2,
    ST_HOLD = 3'd3,
    ST_TAIL = 3'd4
  } state_e;

endpackage

// File: rtl/eth_spi_clkgen.sv
// Half-period timer and SCK edge counter for the SPI master.
module eth_spi_clkgen
  import eth_spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             xfer_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o,
  output logic             odd_edge_o,
  output logic             last_o
);

  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;

  // Compare against div rather than relying on overflow, so div = all-ones is a full span.
  assign tick_o     = run_i && (cnt_q == div_i);
  assign last_o     = tick_o && xfer_i && (edge_q == EDGE_W'(2 * DATA_W - 1));
  assign odd_edge_o = ~edge_q[0];

  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    if (!run_i || tick_o) cnt_d = '0;
    else                  cnt_d = cnt_q + 1'b1;
    if (!xfer_i || last_o) edge_d = '0;
    else if (tick_o)       edge_d = edge_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/eth_spi_master.sv
// SPI master for the Ethernet controller link: configurable width, divider, mode, chip selects and held bursts.
module eth_spi_master
  import eth_spi_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  DIV_W    = DEF_DIV_W,
  parameter int  CS_COUNT = DEF_CS_COUNT,
  localparam int CSW      = $clog2(CS_COUNT) + 1
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CSW-1:0]      cs_sel,
  input  logic [DIV_W-1:0]    div,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                hold,
  input  logic                cs_release,
  output logic [DATA_W-1:0]   rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                eth_sck,
  output logic                eth_mosi,
  input  logic                eth_miso,
  output logic [CS_COUNT-1:0] eth_cs
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                sck_q, sck_d;
  logic                mosi_q, mosi_d;
  logic [CSW-1:0]      cs_sel_q, cs_sel_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                hold_q, hold_d;

  logic                tick, odd_edge, last_edge, sample, accept;
  logic [DATA_W-1:0]   rx_next;

  eth_spi_clkgen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_clkgen (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .run_i     ((state_q == ST_LEAD) || (state_q == ST_XFER) || (state_q == ST_TAIL)),
    .xfer_i    (state_q == ST_XFER),
    .div_i     (div_q),
    .tick_o    (tick),
    .odd_edge_o(odd_edge),
    .last_o    (last_edge)
  );

  assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
  assign busy     = (state_q != ST_IDLE);
  // A release in HOLD outranks a simultaneous word request.
  assign accept   = tx_valid && tx_ready && !((state_q == ST_HOLD) && cs_release);
  assign sample   = odd_edge ^ cpha_q;
  assign rx_next  = {rx_sh_q[DATA_W-2:0], eth_miso};

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign eth_sck  = sck_q;
  assign eth_mosi = mosi_q;

  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_sel_d   = cs_sel_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        sck_d = cpol;
        if (accept) begin
          cs_sel_d = cs_sel;
          div_d    = div;
          cpol_d   = cpol;
          cpha_d   = cpha;
          hold_d   = hold;
          state_d  = ST_LEAD;
          // Mode with cpha=0 presents the MSB before the first SCK edge.
          if (!cpha) begin
            mosi_d  = tx_data[DATA_W-1];
            tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      ST_LEAD: if (tick) state_d = ST_XFER;
      ST_XFER: begin
        if (tick) begin
          sck_d = ~sck_q;
          if (sample) begin
            rx_sh_d = rx_next;
          end else begin
            mosi_d  = tx_sh_q[DATA_W-1];
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          end
        end
        if (last_edge) begin
          rx_data_d  = sample ? rx_next : rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = hold_q ? ST_HOLD : ST_TAIL;
        end
      end
      ST_HOLD: begin
        if (cs_release) begin
          state_d = ST_TAIL;
        end else if (accept) begin
          hold_d  = hold;
          state_d = ST_XFER;
          if (!cpha_q) begin
            mosi_d  = tx_data[DATA_W-1];
            tx_sh_d = {tx_data[DATA_W-2:0], 1'b0};
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      ST_TAIL: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    eth_cs = '1;
    if (state_q != ST_IDLE) begin
      for (int i = 0; i < CS_COUNT; i++) begin
        if (cs_sel_q == CSW'(i)) eth_cs[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_sel_q   <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      cs_sel_q   <= cs_sel_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      hold_q     <= hold_d;
    end
  end

  // Shift registers carry pure data and are always fully reloaded before use.
  always_ff @(posedge clk_in) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

endmodule

// File: tb/tb_eth_spi_master.sv
// Self-checking bench for eth_spi_master: loopback transfers against an SPI-mode reference model.
module tb_eth_spi_master;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic [2:0] cs_sel = '0;
  logic [7:0] div = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       hold = 1'b0;
  logic       cs_release = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       eth_sck;
  logic       eth_mosi;
  logic       eth_miso;
  logic [3:0] eth_cs;

  int n_checks = 0;
  int n_fail = 0;

  // Reference-model state and cumulative monitor counters
  logic        m_cpol = 1'b0;
  logic        m_cpha = 1'b0;
  logic [3:0]  cs_exp = 4'b1110;
  logic [63:0] mosi_hist = '0;
  bit          sck_prev = 1'b0;
  int busy_cyc = 0, hi_cyc = 0, cs_lo_cyc = 0, cs_bad_cyc = 0, edges = 0, rxv_cnt = 0;

  assign eth_miso = ~eth_mosi;

  eth_spi_master #(.DATA_W(8), .DIV_W(8), .CS_COUNT(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .cs_sel(cs_sel), .div(div), .cpol(cpol), .cpha(cpha),
    .hold(hold), .cs_release(cs_release), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .eth_sck(eth_sck), .eth_mosi(eth_mosi), .eth_miso(eth_miso),
    .eth_cs(eth_cs)
  );

  always #5 clk_in = ~clk_in;

  // Slave-side view: record MOSI on each sampling edge as defined by CPOL/CPHA.
  always @(posedge clk_in) begin
    #1;
    if (busy) busy_cyc++;
    if (busy && eth_sck) hi_cyc++;
    if (cs_exp != 4'hF && eth_cs == cs_exp) cs_lo_cyc++;
    if (eth_cs != 4'hF && eth_cs != cs_exp) cs_bad_cyc++;
    if (busy && (eth_sck != sck_prev)) begin
      edges++;
      if ((eth_sck != m_cpol) ^ m_cpha) mosi_hist = {mosi_hist[62:0], eth_mosi};
    end
    sck_prev = eth_sck;
    if (rx_valid) rxv_cnt++;
  end

  task automatic xfer_word(input logic [7:0] d, input logic pol, input logic pha,
                           input logic [7:0] dv, input logic [2:0] sel, input logic hd,
                           input bit prep, output int lat, output logic [7:0] rx,
                           output logic [7:0] mo, output bit to);
    if (prep) begin
      cpol = pol; cpha = pha; div = dv; cs_sel = sel;
      m_cpol = pol; m_cpha = pha;
      cs_exp = (sel < 3'd4) ? ~(4'b0001 << sel) : 4'hF;
      @(negedge clk_in);
    end
    tx_data = d; hold = hd; tx_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tx_valid = 1'b0;
    lat = 1;
    while (rx_valid !== 1'b1 && lat < 3000) begin
      @(negedge clk_in);
      lat++;
    end
    to = (rx_valid !== 1'b1);
    rx = rx_data;
    mo = mosi_hist[7:0];
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    n_checks++; if (eth_cs !== 4'hF) begin n_fail++; $display("FAIL reset_cs got=%b exp=1111", eth_cs); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    n_checks++; if (eth_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck got=%b exp=0", eth_sck); end
    n_checks++; if (eth_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi got=%b exp=0", eth_mosi); end
  endtask

  task automatic test_mode0();
    int lat, c0, e0, h0, v0, b0;
    logic [7:0] rx, mo;
    bit to, ok;
    c0 = cs_lo_cyc; e0 = edges; h0 = hi_cyc; v0 = rxv_cnt; b0 = cs_bad_cyc;
    xfer_word(8'hA5, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, lat, rx, mo, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL m0_timeout got=none exp=rx_valid"); end
    n_checks++; if (rx !== 8'h5A) begin n_fail++; $display("FAIL m0_rx got=%h exp=5a", rx); end
    n_checks++; if (mo !== 8'hA5) begin n_fail++; $display("FAIL m0_mosi got=%h exp=a5", mo); end
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL m0_latency got=%0d exp=18", lat); end
    @(negedge clk_in);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL m0_rxv_width got=%b exp=0", rx_valid); end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL m0_idle got=busy exp=idle"); end
    n_checks++; if (cs_lo_cyc - c0 !== 18) begin n_fail++; $display("FAIL m0_cs_low got=%0d exp=18", cs_lo_cyc - c0); end
    n_checks++; if (edges - e0 !== 16) begin n_fail++; $display("FAIL m0_edges got=%0d exp=16", edges - e0); end
    n_checks++; if (hi_cyc - h0 !== 8) begin n_fail++; $display("FAIL m0_sck_high got=%0d exp=8", hi_cyc - h0); end
    n_checks++; if (rxv_cnt - v0 !== 1) begin n_fail++; $display("FAIL m0_rxv_count got=%0d exp=1", rxv_cnt - v0); end
    n_checks++; if (cs_bad_cyc !== b0) begin n_fail++; $display("FAIL m0_cs_other got=%0d exp=%0d", cs_bad_cyc, b0); end
    n_checks++; if (eth_sck !== 1'b0) begin n_fail++; $display("FAIL m0_sck_idle got=%b exp=0", eth_sck); end
  endtask

  // Modes 1..3 with div=3, then randomized word/mode/divider/select.
  task automatic test_modes();
    int lat, c0, e0, h0, hh;
    logic [7:0] d, rx, mo, dv;
    logic pol, pha;
    logic [2:0] sel;
    bit to, ok;
    for (int it = 0; it < 9; it++) begin
      if (it < 3) begin
        d = 8'hA5; dv = 8'd3; sel = 3'd0;
        pol = (it >= 1); pha = (it != 1);
      end else begin
        d = 8'($urandom); dv = 8'($urandom_range(0, 5)); sel = 3'($urandom_range(0, 3));
        pol = 1'($urandom); pha = 1'($urandom);
      end
      hh = int'(dv) + 1;
      c0 = cs_lo_cyc; e0 = edges; h0 = hi_cyc;
      xfer_word(d, pol, pha, dv, sel, 1'b0, 1'b1, lat, rx, mo, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL modes_timeout it=%0d", it); end
      n_checks++; if (rx !== ~d) begin n_fail++; $display("FAIL modes_rx it=%0d got=%h exp=%h", it, rx, ~d); end
      n_checks++; if (mo !== d) begin n_fail++; $display("FAIL modes_mosi it=%0d got=%h exp=%h", it, mo, d); end
      n_checks++; if (lat !== 1 + 17 * hh) begin n_fail++; $display("FAIL modes_latency it=%0d got=%0d exp=%0d", it, lat, 1 + 17 * hh); end
      wait_idle(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL modes_idle it=%0d got=busy exp=idle", it); end
      n_checks++; if (cs_lo_cyc - c0 !== 18 * hh) begin n_fail++; $display("FAIL modes_cs_low it=%0d got=%0d exp=%0d", it, cs_lo_cyc - c0, 18 * hh); end
      n_checks++; if (edges - e0 !== 16) begin n_fail++; $display("FAIL modes_edges it=%0d got=%0d exp=16", it, edges - e0); end
      n_checks++; if (hi_cyc - h0 !== (pol ? 10 * hh : 8 * hh)) begin n_fail++; $display("FAIL modes_sck_high it=%0d got=%0d exp=%0d", it, hi_cyc - h0, pol ? 10 * hh : 8 * hh); end
      n_checks++; if (eth_sck !== pol) begin n_fail++; $display("FAIL modes_sck_idle it=%0d got=%b exp=%b", it, eth_sck, pol); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3] = '{8'h12, 8'h34, 8'h56};
    int lat, c0, b0;
    logic [7:0] rx, mo;
    bit to, ok;
    c0 = cs_lo_cyc; b0 = cs_bad_cyc;
    for (int w = 0; w < 3; w++) begin
      if (w == 1) begin cs_sel = 3'd1; div = 8'd7; cpol = 1'b0; cpha = 1'b0; end
      if (w == 2) begin cs_sel = 3'd0; div = 8'd1; cpol = 1'b1; cpha = 1'b1; end
      xfer_word(words[w], 1'b1, 1'b1, 8'd1, 3'd0, (w < 2), (w == 0), lat, rx, mo, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL burst_timeout w=%0d", w); end
      n_checks++; if (rx !== ~words[w]) begin n_fail++; $display("FAIL burst_rx w=%0d got=%h exp=%h", w, rx, ~words[w]); end
      n_checks++; if (mo !== words[w]) begin n_fail++; $display("FAIL burst_mosi w=%0d got=%h exp=%h", w, mo, words[w]); end
      n_checks++; if (lat !== (w == 0 ? 35 : 33)) begin n_fail++; $display("FAIL burst_latency w=%0d got=%0d exp=%0d", w, lat, w == 0 ? 35 : 33); end
    end
    wait_idle(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL burst_idle got=busy exp=idle"); end
    n_checks++; if (cs_lo_cyc - c0 !== 102) begin n_fail++; $display("FAIL burst_cs_low got=%0d exp=102", cs_lo_cyc - c0); end
    n_checks++; if (cs_bad_cyc !== b0) begin n_fail++; $display("FAIL burst_cs_other got=%0d exp=%0d", cs_bad_cyc, b0); end
  endtask

  task automatic test_release();
    int lat, v0, lo;
    logic [7:0] rx, mo;
    bit to;
    v0 = rxv_cnt;
    xfer_word(8'h3C, 1'b0, 1'b0, 8'd2, 3'd0, 1'b1, 1'b1, lat, rx, mo, to);
    n_checks++; if (rx !== 8'hC3) begin n_fail++; $display("FAIL rel_first_rx got=%h exp=c3", rx); end
    tx_data = 8'hFF; hold = 1'b0; tx_valid = 1'b1; cs_release = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tx_valid = 1'b0; cs_release = 1'b0;
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL rel_tail_ready got=%b exp=0", tx_ready); end
    lo = (eth_cs[0] === 1'b0) ? 1 : 0;
    repeat (3) begin
      @(negedge clk_in);
      if (eth_cs[0] === 1'b0) lo++;
    end
    n_checks++; if (lo !== 3) begin n_fail++; $display("FAIL rel_tail_len got=%0d exp=3", lo); end
    n_checks++; if (eth_cs !== 4'hF) begin n_fail++; $display("FAIL rel_cs_high got=%b exp=1111", eth_cs); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rel_idle got=%b exp=0", busy); end
    repeat (10) @(negedge clk_in);
    n_checks++; if (rxv_cnt - v0 !== 1) begin n_fail++; $display("FAIL rel_no_word got=%0d exp=1", rxv_cnt - v0); end
    n_checks++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rel_rx_kept got=%h exp=c3", rx_data); end
  endtask

  task automatic test_cs_select();
    int lat, c0, b0;
    logic [7:0] rx, mo;
    bit to, ok;
    c0 = cs_lo_cyc; b0 = cs_bad_cyc;
    xfer_word(8'h96, 1'b0, 1'b0, 8'd1, 3'd2, 1'b0, 1'b1, lat, rx, mo, to);
    wait_idle(ok);
    n_checks++; if (rx !== 8'h69) begin n_fail++; $display("FAIL cs2_rx got=%h exp=69", rx); end
    n_checks++; if (cs_lo_cyc - c0 !== 36) begin n_fail++; $display("FAIL cs2_low got=%0d exp=36", cs_lo_cyc - c0); end
    n_checks++; if (cs_bad_cyc !== b0) begin n_fail++; $display("FAIL cs2_other got=%0d exp=%0d", cs_bad_cyc, b0); end
    xfer_word(8'h0F, 1'b0, 1'b1, 8'd1, 3'd5, 1'b0, 1'b1, lat, rx, mo, to);
    wait_idle(ok);
    n_checks++; if (to) begin n_fail++; $display("FAIL cs5_timeout got=none exp=rx_valid"); end
    n_checks++; if (rx !== 8'hF0) begin n_fail++; $display("FAIL cs5_rx got=%h exp=f0", rx); end
    n_checks++; if (lat !== 35) begin n_fail++; $display("FAIL cs5_latency got=%0d exp=35", lat); end
    n_checks++; if (cs_bad_cyc !== b0) begin n_fail++; $display("FAIL cs5_any_low got=%0d exp=%0d", cs_bad_cyc, b0); end
  endtask

  task automatic test_reset_mid();
    int lat, v0;
    logic [7:0] rx, mo;
    bit to;
    cpol = 1'b0; cpha = 1'b1; div = 8'd3; cs_sel = 3'd0;
    m_cpol = 1'b0; m_cpha = 1'b1; cs_exp = 4'b1110;
    @(negedge clk_in);
    tx_data = 8'hC7; hold = 1'b0; tx_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk_in);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstm_midxfer got=%b exp=1", busy); end
    v0 = rxv_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++; if (eth_cs !== 4'hF) begin n_fail++; $display("FAIL rstm_cs got=%b exp=1111", eth_cs); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstm_busy got=%b exp=0", busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstm_ready got=%b exp=1", tx_ready); end
    n_checks++; if (eth_sck !== 1'b0) begin n_fail++; $display("FAIL rstm_sck got=%b exp=0", eth_sck); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstm_rx_data got=%h exp=00", rx_data); end
    repeat (5) @(negedge clk_in);
    n_checks++; if (rxv_cnt !== v0) begin n_fail++; $display("FAIL rstm_no_rxv got=%0d exp=%0d", rxv_cnt, v0); end
    rst_n = 1'b1;
    @(negedge clk_in);
    xfer_word(8'h3B, 1'b0, 1'b0, 8'd0, 3'd0, 1'b0, 1'b1, lat, rx, mo, to);
    n_checks++; if (rx !== 8'hC4) begin n_fail++; $display("FAIL rstm_after_rx got=%h exp=c4", rx); end
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL rstm_after_latency got=%0d exp=18", lat); end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    test_mode0();
    test_modes();
    test_back_to_back();
    test_release();
    test_cs_select();
    test_reset_mid();
    repeat (5) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
